serial_subtractor3: RTL and testbench

Bit-serial two's-complement subtractor computing D = A − B − B_in, one bit per clock, LSB first. It reuses a single borrow flip-flop instead of a ripple chain, so it is the subtracting counterpart to the team's 3-bit ripple adder. A start/busy/done handshake lets a controlling FSM launch an operation and collect a registered result. The default width is 3 bits, matching the adder datapath.

---
 rtl/serial_subtractor3_if.sv | 39 +++
 rtl/serial_subtractor3.sv | 124 ++++++++++++
 tb/tb_serial_subtractor3.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor3_if.sv
// ----------------------------------------------------------------------------
// serial_subtractor3_if
//   Handshake and data bundle for the bit-serial subtractor.
//
//   master : drives start, A, B, B_in; observes busy, done, D, B_out, V
//   slave  : the subtractor itself (the opposite directions)
//
//   start  - request a new operation (taken only when the slave is idle/done)
//   A, B   - minuend / subtrahend, WIDTH bits
//   B_in   - borrow-in
//   busy   - operation in progress
//   done   - one-cycle pulse, result valid from this cycle on
//   D      - registered difference (A - B - B_in) mod 2^WIDTH
//   B_out  - registered borrow-out
//   V      - registered signed-overflow flag
// ----------------------------------------------------------------------------
interface serial_subtractor3_if #(
    parameter int WIDTH = 3
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             B_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             B_out;
    logic             V;

    modport master (
        output start, A, B, B_in,
        input  busy, done, D, B_out, V
    );

    modport slave (
        input  start, A, B, B_in,
        output busy, done, D, B_out, V
    );
endinterface

// File: rtl/serial_subtractor3.sv
// ----------------------------------------------------------------------------
// serial_subtractor3
//   Bit-serial two's-complement subtractor, D = A - B - B_in, one bit per
//   clock, LSB first, using a single borrow flop. A start/busy/done handshake
//   launches an operation; results are registered and held until the next
//   completion.
//
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - serial_subtractor3_if.slave (start, A, B, B_in in;
//            busy, done, D, B_out, V out)
//
//   Timing: start sampled at edge E0 -> busy after E0, result loaded and done
//   pulsed after edge E{WIDTH}. In the DONE cycle a new start is accepted,
//   giving one result every WIDTH+1 cycles when start is held high.
// ----------------------------------------------------------------------------
module serial_subtractor3 #(
    parameter int WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor3_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             bor_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] d_reg;
    logic             b_out_reg;
    logic             v_reg;
    logic             busy_reg;
    logic             done_reg;

    // Current bit slice. The operand registers shift right, so bit 0 always
    // holds bit i of the original operand; on the last bit it is the sign bit,
    // which is all the overflow flag needs.
    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             bor_next;
    logic [WIDTH-1:0] diff_next;
    logic             last_bit;

    always_comb begin
        a_bit     = a_sh_reg[0];
        b_bit     = b_sh_reg[0];
        d_bit     = a_bit ^ b_bit ^ bor_reg;
        bor_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bor_reg);
        // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
        diff_next = {d_bit, diff_reg[WIDTH-1:1]};
        last_bit  = (cnt_reg == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            diff_reg  <= '0;
            bor_reg   <= 1'b0;
            cnt_reg   <= '0;
            d_reg     <= '0;
            b_out_reg <= 1'b0;
            v_reg     <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    a_sh_reg <= a_sh_reg >> 1;
                    b_sh_reg <= b_sh_reg >> 1;
                    diff_reg <= diff_next;
                    bor_reg  <= bor_next;
                    if (last_bit) begin
                        cnt_reg   <= '0;
                        d_reg     <= diff_next;
                        b_out_reg <= bor_next;
                        // Operand signs differ and the result sign left A's.
                        v_reg     <= (a_bit != b_bit) && (d_bit != a_bit);
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: begin
                    // IDLE and DONE behave identically apart from the done
                    // pulse, which always drops after one cycle.
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        a_sh_reg  <= bus.A;
                        b_sh_reg  <= bus.B;
                        diff_reg  <= '0;
                        bor_reg   <= bus.B_in;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy  = busy_reg;
    assign bus.done  = done_reg;
    assign bus.D     = d_reg;
    assign bus.B_out = b_out_reg;
    assign bus.V     = v_reg;

endmodule

// File: tb/tb_serial_subtractor3.sv
// ----------------------------------------------------------------------------
// tb_serial_subtractor3
//   Scoreboard bench: each issued operation pushes its expected result and
//   completion cycle; an independent monitor pops and compares whenever done
//   is seen. Expected values come from plain integer arithmetic.
// ----------------------------------------------------------------------------
module tb_serial_subtractor3;

    localparam int W = 3;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    serial_subtractor3_if #(.WIDTH(W)) bus ();

    serial_subtractor3 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         v;
        int           cyc;
        int           a;
        int           b;
        int           bin;
    } exp_t;

    exp_t sb[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input int a, input int b, input int bin, input int c);
        exp_t e;
        int   diff;
        int   mask;
        int   am;
        int   bm;
        int   dm;
        mask  = (1 << W) - 1;
        diff  = (a - b - bin) & mask;
        am    = (a >> (W - 1)) & 1;
        bm    = (b >> (W - 1)) & 1;
        dm    = (diff >> (W - 1)) & 1;
        e.d   = W'(diff);
        e.bo  = (a < b + bin);
        e.v   = (am != bm) && (dm != am);
        e.cyc = c;
        e.a   = a;
        e.b   = b;
        e.bin = bin;
        return e;
    endfunction

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            check("busy_done_exclusive", {31'b0, bus.busy & bus.done}, 32'd0);
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    $display("op A=%0d B=%0d Bin=%0d -> D=%0d Bout=%0d V=%0d (exp %0d %0d %0d)",
                             e.a, e.b, e.bin, bus.D, bus.B_out, bus.V, e.d, e.bo, e.v);
                    check("D", {29'b0, bus.D}, {29'b0, e.d});
                    check("B_out", {31'b0, bus.B_out}, {31'b0, e.bo});
                    check("V", {31'b0, bus.V}, {31'b0, e.v});
                    check("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Called at a negedge where the DUT is in IDLE or DONE. Returns at the
    // negedge of the DONE cycle with start low. With junk set, start and the
    // operands are scrambled throughout RUN, which must have no effect.
    task automatic do_op(input int a, input int b, input int bin, input bit junk);
        bus.start = 1'b1;
        bus.A     = W'(a);
        bus.B     = W'(b);
        bus.B_in  = bin[0];
        sb.push_back(model(a, b, bin, cyc + 1 + W));
        @(negedge clk);
        for (int k = 0; k < W; k++) begin
            check("busy_in_run", {31'b0, bus.busy}, 32'd1);
            if (junk) begin
                bus.start = $urandom_range(0, 1) != 0;
                bus.A     = W'($urandom);
                bus.B     = W'($urandom);
                bus.B_in  = $urandom_range(0, 1) != 0;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        check("busy_after_run", {31'b0, bus.busy}, 32'd0);
        check("done_pulse", {31'b0, bus.done}, 32'd1);
        bus.start = 1'b0;
    endtask

    initial begin
        int a;
        int b;
        int bin;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.B_in  = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_D", {29'b0, bus.D}, 32'd0);
        check("rst_B_out", {31'b0, bus.B_out}, 32'd0);
        check("rst_V", {31'b0, bus.V}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic subtract, then the result must hold through IDLE.
        do_op(5, 3, 0, 1'b0);
        repeat (4) @(negedge clk);
        check("D_hold_idle", {29'b0, bus.D}, 32'd2);
        check("idle_no_busy", {31'b0, bus.busy}, 32'd0);

        // Abort mid-RUN with an asynchronous reset.
        bus.start = 1'b1;
        bus.A     = W'(7);
        bus.B     = W'(1);
        bus.B_in  = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        check("abort_done", {31'b0, bus.done}, 32'd0);
        check("abort_D", {29'b0, bus.D}, 32'd0);
        check("abort_B_out", {31'b0, bus.B_out}, 32'd0);
        check("abort_V", {31'b0, bus.V}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_abort_busy", {31'b0, bus.busy}, 32'd0);
        check("post_abort_D", {29'b0, bus.D}, 32'd0);

        // Directed borrow / overflow / borrow-in cases.
        do_op(3, 5, 0, 1'b0);
        @(negedge clk);
        do_op(3, 4, 0, 1'b1);
        @(negedge clk);
        do_op(0, 0, 1, 1'b0);
        @(negedge clk);
        do_op(7, 7, 1, 1'b1);

        // Back-to-back: start re-accepted in the DONE cycle.
        do_op(5, 3, 0, 1'b1);
        do_op(6, 1, 0, 1'b0);
        repeat (2) @(negedge clk);

        // Exhaustive sweep with random gaps and RUN-time scrambling.
        for (int i = 0; i < 128; i++) begin
            a   = i % 8;
            b   = (i / 8) % 8;
            bin = i / 64;
            do_op(a, b, bin, $urandom_range(0, 1) != 0);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end

        // A few extra random operations.
        for (int i = 0; i < 40; i++) begin
            do_op($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 1) != 0);
            if ($urandom_range(0, 1) == 0) begin
                @(negedge clk);
            end
        end

        repeat (6) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
